// File: rtl/entrada_pkg.sv
// Shared definitions for the entrada_debounce key/switch capture block.
// FSM state encoding and the default debounce length (1 ms at 50 MHz).
package entrada_pkg;

    localparam int DEBOUNCE_DEFAULT = 50000;

    typedef enum logic [1:0] {
        SOLTO          = 2'b00,
        CONFIRMA_PRESS = 2'b01,
        PRESSIONADO    = 2'b10,
        CONFIRMA_SOLTA = 2'b11
    } estado_t;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for asynchronous board inputs.
// The reset value is a parameter so idle levels (e.g. released key = 1) are preserved.
module sincronizador #(
    parameter int             W         = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/entrada_debounce.sv
// Debounced board key that captures the switch bank on each accepted press.
// Optional sticky overrun flag is built only when ENTRADA_OVERRUN_EN is defined.
//
// state          | meaning
// SOLTO          | key released and accepted as released; waiting for a press
// CONFIRMA_PRESS | key reads pressed; counting stable pressed cycles
// PRESSIONADO    | press accepted; waiting for a release
// CONFIRMA_SOLTA | key reads released; counting stable released cycles
module entrada_debounce
    import entrada_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DATA_W          = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              botaoPlaca,
    input  logic [DATA_W-1:0] entradaDeDados,
    input  logic              comandoIN,
    output logic              botaoIN,
    output logic              dadoValido,
    output logic [DATA_W-1:0] dadosCapturados,
    output logic              overrun
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic              key_sync;
    logic [DATA_W-1:0] data_sync;
    logic              pressed;

    estado_t           estado, estado_prox;
    logic [CNT_W-1:0]  cnt, cnt_prox, cnt_inc;
    logic              aceita;

    sincronizador #(.W(1), .RESET_VAL(1'b1)) u_sync_key (
        .clock (clock),
        .reset (reset),
        .d     (botaoPlaca),
        .q     (key_sync)
    );

    sincronizador #(.W(DATA_W), .RESET_VAL('0)) u_sync_data (
        .clock (clock),
        .reset (reset),
        .d     (entradaDeDados),
        .q     (data_sync)
    );

    assign pressed = ~key_sync;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= SOLTO;
            cnt    <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
        end
    end

    // The sample that leaves a stable state is itself the first stable cycle,
    // so the confirm states finish when the count reaches DEBOUNCE_CYCLES-1.
    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        aceita      = 1'b0;
        case (estado)
            SOLTO: begin
                if (pressed) begin
                    cnt_prox = '0;
                    if (CNT_LAST == '0) begin
                        estado_prox = PRESSIONADO;
                        aceita      = 1'b1;
                    end else begin
                        estado_prox = CONFIRMA_PRESS;
                    end
                end
            end
            CONFIRMA_PRESS: begin
                if (!pressed) begin
                    estado_prox = SOLTO;
                    cnt_prox    = '0;
                end else if (cnt_inc >= CNT_LAST) begin
                    estado_prox = PRESSIONADO;
                    cnt_prox    = '0;
                    aceita      = 1'b1;
                end else begin
                    cnt_prox = cnt_inc;
                end
            end
            PRESSIONADO: begin
                if (!pressed) begin
                    cnt_prox    = '0;
                    estado_prox = (CNT_LAST == '0) ? SOLTO : CONFIRMA_SOLTA;
                end
            end
            CONFIRMA_SOLTA: begin
                if (pressed) begin
                    estado_prox = PRESSIONADO;
                    cnt_prox    = '0;
                end else if (cnt_inc >= CNT_LAST) begin
                    estado_prox = SOLTO;
                    cnt_prox    = '0;
                end else begin
                    cnt_prox = cnt_inc;
                end
            end
            default: begin
                estado_prox = SOLTO;
                cnt_prox    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            botaoIN         <= 1'b0;
            dadoValido      <= 1'b0;
            dadosCapturados <= '0;
        end else begin
            botaoIN <= aceita;
            if (aceita) begin
                dadoValido      <= 1'b1;
                dadosCapturados <= data_sync;
            end else if (comandoIN) begin
                dadoValido <= 1'b0;
            end
        end
    end

`ifdef ENTRADA_OVERRUN_EN
    // A consume on the acceptance cycle frees the slot, so it is not an overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (aceita && dadoValido && !comandoIN) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule
